// File: rtl/traffic_light_monitor.sv
// In-system checker for a 3-bit one-hot traffic light (red 001, yellow 010, green 100).
// Locks onto the red->yellow->green order, then flags encoding, order and dwell-time errors.
module traffic_light_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int DWELL_W   = 8,
  parameter int CYC_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         light,
  input  logic               clr_err,
  output logic               locked,
  output logic [1:0]         cur_phase,
  output logic [DWELL_W-1:0] dwell,
  output logic [CYC_W-1:0]   cycle_count,
  output logic               err_onehot,
  output logic               err_seq,
  output logic               err_dwell,
  output logic               err_sticky
);

  typedef enum logic {ACQUIRE, TRACK} state_t;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  localparam logic [DWELL_W-1:0] DWELL_SAT = '1;
  localparam logic [DWELL_W-1:0] MIN_D     = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] MAX_D     = DWELL_W'(MAX_DWELL);

  state_t     state;
  logic [2:0] prev_light;

  logic       light_legal;
  logic       prev_legal;
  logic [2:0] next_code;
  logic [1:0] light_code;
  logic       hold;
  logic       advance;
  logic       onehot_d;
  logic       seq_d;
  logic       dwell_d;

  // Classify the current and previous samples and decide which error pulses fire.
  always_comb begin
    next_code  = 3'b000;
    light_code = 2'b00;
    case (prev_light)
      RED:     next_code = YELLOW;
      YELLOW:  next_code = GREEN;
      GREEN:   next_code = RED;
      default: next_code = 3'b000;
    endcase
    case (light)
      YELLOW:  light_code = 2'b01;
      GREEN:   light_code = 2'b10;
      default: light_code = 2'b00;
    endcase
    light_legal = (light == RED) || (light == YELLOW) || (light == GREEN);
    prev_legal  = (prev_light == RED) || (prev_light == YELLOW) || (prev_light == GREEN);
    hold        = (state == TRACK) && light_legal && (light == prev_light);
    advance     = (state == TRACK) && light_legal && (light == next_code);
    onehot_d    = !light_legal;
    seq_d       = (state == TRACK) && light_legal && !hold && !advance;
    // The over-long pulse fires only on the step past MAX_DWELL, never once saturated.
    dwell_d     = (hold && (dwell == MAX_D) && (dwell != DWELL_SAT)) ||
                  (advance && (dwell < MIN_D));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACQUIRE;
      prev_light  <= 3'b000;
      locked      <= 1'b0;
      cur_phase   <= 2'b00;
      dwell       <= '0;
      cycle_count <= '0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
      err_dwell   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      prev_light <= light;
      err_onehot <= onehot_d;
      err_seq    <= seq_d;
      err_dwell  <= dwell_d;
      err_sticky <= onehot_d || seq_d || dwell_d || (err_sticky && !clr_err);
      if (state == ACQUIRE) begin
        if (light_legal && prev_legal && (light == next_code)) begin
          state       <= TRACK;
          locked      <= 1'b1;
          dwell       <= DWELL_W'(1);
          cur_phase   <= light_code;
          cycle_count <= '0;
        end
      end else begin
        if (!light_legal || seq_d) begin
          state  <= ACQUIRE;
          locked <= 1'b0;
        end else if (hold) begin
          if (dwell != DWELL_SAT) dwell <= dwell + DWELL_W'(1);
        end else begin
          dwell     <= DWELL_W'(1);
          cur_phase <= light_code;
          if (prev_light == GREEN) cycle_count <= cycle_count + CYC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Drives one light stream into three differently parameterised monitors and checks
// each against a phase-index model every cycle, plus hand-computed spot values.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light;
  logic       clr_err;

  logic        a_locked, a_eo, a_es, a_ed, a_sticky;
  logic [1:0]  a_phase;
  logic [7:0]  a_dwell;
  logic [15:0] a_cyc;
  logic        b_locked, b_eo, b_es, b_ed, b_sticky;
  logic [1:0]  b_phase;
  logic [7:0]  b_dwell;
  logic [15:0] b_cyc;
  logic        c_locked, c_eo, c_es, c_ed, c_sticky;
  logic [1:0]  c_phase;
  logic [1:0]  c_dwell;
  logic [1:0]  c_cyc;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  traffic_light_monitor dut_a (
    .clk(clk), .rst(rst), .light(light), .clr_err(clr_err),
    .locked(a_locked), .cur_phase(a_phase), .dwell(a_dwell), .cycle_count(a_cyc),
    .err_onehot(a_eo), .err_seq(a_es), .err_dwell(a_ed), .err_sticky(a_sticky));

  traffic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3)) dut_b (
    .clk(clk), .rst(rst), .light(light), .clr_err(clr_err),
    .locked(b_locked), .cur_phase(b_phase), .dwell(b_dwell), .cycle_count(b_cyc),
    .err_onehot(b_eo), .err_seq(b_es), .err_dwell(b_ed), .err_sticky(b_sticky));

  traffic_light_monitor #(.DWELL_W(2), .CYC_W(2)) dut_c (
    .clk(clk), .rst(rst), .light(light), .clr_err(clr_err),
    .locked(c_locked), .cur_phase(c_phase), .dwell(c_dwell), .cycle_count(c_cyc),
    .err_onehot(c_eo), .err_seq(c_es), .err_dwell(c_ed), .err_sticky(c_sticky));

  // Gather the three DUTs into common-width arrays for the per-cycle compare.
  logic [31:0] d_locked[3], d_phase[3], d_dwell[3], d_cyc[3];
  logic [31:0] d_eo[3], d_es[3], d_ed[3], d_sticky[3];
  always_comb begin
    d_locked[0] = 32'(a_locked); d_locked[1] = 32'(b_locked); d_locked[2] = 32'(c_locked);
    d_phase[0]  = 32'(a_phase);  d_phase[1]  = 32'(b_phase);  d_phase[2]  = 32'(c_phase);
    d_dwell[0]  = 32'(a_dwell);  d_dwell[1]  = 32'(b_dwell);  d_dwell[2]  = 32'(c_dwell);
    d_cyc[0]    = 32'(a_cyc);    d_cyc[1]    = 32'(b_cyc);    d_cyc[2]    = 32'(c_cyc);
    d_eo[0]     = 32'(a_eo);     d_eo[1]     = 32'(b_eo);     d_eo[2]     = 32'(c_eo);
    d_es[0]     = 32'(a_es);     d_es[1]     = 32'(b_es);     d_es[2]     = 32'(c_es);
    d_ed[0]     = 32'(a_ed);     d_ed[1]     = 32'(b_ed);     d_ed[2]     = 32'(c_ed);
    d_sticky[0] = 32'(a_sticky); d_sticky[1] = 32'(b_sticky); d_sticky[2] = 32'(c_sticky);
  end

  // Model configuration and state, one slot per DUT; phases are indices 0..2, -1 = illegal.
  int cfg_min[3] = '{1, 2, 1};
  int cfg_max[3] = '{1, 3, 1};
  int cfg_dw[3]  = '{8, 8, 2};
  int cfg_cw[3]  = '{16, 16, 2};
  int m_locked[3], m_phase[3], m_dwell[3], m_cyc[3];
  int m_eo[3], m_es[3], m_ed[3], m_sticky[3], m_prev[3];

  function automatic int code_idx(input logic [2:0] l);
    case (l)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_step(input int k);
    int li, sat;
    sat = (1 << cfg_dw[k]) - 1;
    if (rst) begin
      m_locked[k] = 0; m_phase[k] = 0; m_dwell[k] = 0; m_cyc[k] = 0;
      m_eo[k] = 0; m_es[k] = 0; m_ed[k] = 0; m_sticky[k] = 0; m_prev[k] = -1;
      return;
    end
    li = code_idx(light);
    m_eo[k] = (li < 0) ? 1 : 0;
    m_es[k] = 0;
    m_ed[k] = 0;
    if (m_locked[k] == 0) begin
      if (li >= 0 && m_prev[k] >= 0 && li == (m_prev[k] + 1) % 3) begin
        m_locked[k] = 1; m_dwell[k] = 1; m_phase[k] = li; m_cyc[k] = 0;
      end
    end else if (li < 0) begin
      m_locked[k] = 0;
    end else if (li == m_prev[k]) begin
      if (m_dwell[k] == cfg_max[k] && m_dwell[k] < sat) m_ed[k] = 1;
      if (m_dwell[k] < sat) m_dwell[k] = m_dwell[k] + 1;
    end else if (li == (m_prev[k] + 1) % 3) begin
      m_ed[k] = (m_dwell[k] < cfg_min[k]) ? 1 : 0;
      m_dwell[k] = 1;
      m_phase[k] = li;
      if (m_prev[k] == 2) m_cyc[k] = (m_cyc[k] + 1) % (1 << cfg_cw[k]);
    end else begin
      m_es[k] = 1;
      m_locked[k] = 0;
    end
    m_sticky[k] = (m_eo[k] | m_es[k] | m_ed[k]) | (m_sticky[k] & (clr_err ? 0 : 1));
    m_prev[k] = li;
  endtask

  // Inputs change only on negedge+2, so at negedge they still hold what the last posedge sampled.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    if (rst) started = 1'b1;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("dut%0d_locked", k), d_locked[k], m_locked[k]);
        checkOutput($sformatf("dut%0d_phase", k),  d_phase[k],  m_phase[k]);
        checkOutput($sformatf("dut%0d_dwell", k),  d_dwell[k],  m_dwell[k]);
        checkOutput($sformatf("dut%0d_cycles", k), d_cyc[k],    m_cyc[k]);
        checkOutput($sformatf("dut%0d_err_onehot", k), d_eo[k], m_eo[k]);
        checkOutput($sformatf("dut%0d_err_seq", k),    d_es[k], m_es[k]);
        checkOutput($sformatf("dut%0d_err_dwell", k),  d_ed[k], m_ed[k]);
        checkOutput($sformatf("dut%0d_err_sticky", k), d_sticky[k], m_sticky[k]);
      end
    end
  end

  // Present one sample; returns once the registered response is visible.
  task automatic applyStimulus(input logic [2:0] l, input logic r, input logic c);
    light   = l;
    rst     = r;
    clr_err = c;
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  int exp_c_cyc[5]   = '{1, 2, 3, 0, 1};
  int exp_c_dwell[5] = '{2, 3, 3, 3, 3};

  initial begin
    light = 3'b000; rst = 1'b1; clr_err = 1'b0;
    applyStimulus(3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("reset_locked", a_locked, 0);
    checkOutput("reset_dwell",  a_dwell,  0);
    checkOutput("reset_cycles", a_cyc,    0);
    checkOutput("reset_sticky", a_sticky, 0);

    // Lock-on and full cycles, with wrap of the 2-bit cycle counter.
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("acq_not_locked", a_locked, 0);
    applyStimulus(Y, 1'b0, 1'b0);
    checkOutput("lock_locked", a_locked, 1);
    checkOutput("lock_phase",  a_phase,  1);
    checkOutput("lock_dwell",  a_dwell,  1);
    checkOutput("lock_cycles", a_cyc,    0);
    applyStimulus(G, 1'b0, 1'b0);
    for (int w = 1; w <= 5; w++) begin
      applyStimulus(R, 1'b0, 1'b0);
      checkOutput($sformatf("wrap%0d_cycles_a", w), a_cyc, w);
      checkOutput($sformatf("wrap%0d_cycles_c", w), c_cyc, exp_c_cyc[w-1]);
      checkOutput($sformatf("wrap%0d_dwell_a", w), a_dwell, 1);
      if (w < 5) begin
        applyStimulus(Y, 1'b0, 1'b0);
        applyStimulus(G, 1'b0, 1'b0);
      end
    end
    checkOutput("run_sticky_a", a_sticky, 0);

    // Illegal code while locked, then relock.
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkOutput("onehot_pulse",  a_eo,     1);
    checkOutput("onehot_unlock", a_locked, 0);
    checkOutput("onehot_sticky", a_sticky, 1);
    checkOutput("onehot_no_seq", a_es,     0);
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("onehot_pulse_end", a_eo, 0);
    checkOutput("relock_wait",      a_locked, 0);
    applyStimulus(Y, 1'b0, 1'b0);
    checkOutput("relock_locked", a_locked, 1);
    checkOutput("relock_cycles", a_cyc,    0);

    // Skip from red straight to green.
    applyStimulus(G, 1'b0, 1'b0);
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("pre_skip_cycles", a_cyc,   1);
    checkOutput("pre_skip_phase",  a_phase, 0);
    applyStimulus(G, 1'b0, 1'b0);
    checkOutput("skip_seq",       a_es,     1);
    checkOutput("skip_unlock",    a_locked, 0);
    checkOutput("skip_no_onehot", a_eo,     0);
    applyStimulus(3'b111, 1'b0, 1'b0);
    checkOutput("acq_onehot", a_eo, 1);
    applyStimulus(G, 1'b0, 1'b0);
    applyStimulus(R, 1'b0, 1'b0);
    checkOutput("relock2_locked", a_locked, 1);
    checkOutput("relock2_phase",  a_phase,  0);

    // Clear colliding with a new error, then a clean clear.
    applyStimulus(G, 1'b0, 1'b1);
    checkOutput("clr_vs_seq_pulse",  a_es,     1);
    checkOutput("clr_vs_seq_sticky", a_sticky, 1);
    applyStimulus(R, 1'b0, 1'b1);
    checkOutput("clr_sticky_a", a_sticky, 0);
    checkOutput("clr_sticky_b", b_sticky, 0);
    checkOutput("clr_locked",   a_locked, 1);

    // Short red then a long yellow on all three dwell configurations.
    applyStimulus(Y, 1'b0, 1'b0);
    checkOutput("short_red_b", b_ed, 1);
    checkOutput("short_red_a", a_ed, 0);
    for (int i = 2; i <= 6; i++) begin
      applyStimulus(Y, 1'b0, 1'b0);
      checkOutput($sformatf("hold%0d_err_b", i), b_ed, (i == 4) ? 1 : 0);
      checkOutput($sformatf("hold%0d_err_a", i), a_ed, (i == 2) ? 1 : 0);
      checkOutput($sformatf("hold%0d_dwell_c", i), c_dwell, exp_c_dwell[i-2]);
      if (i == 5) begin
        checkOutput("hold5_dwell_b",  b_dwell,  5);
        checkOutput("hold5_locked_b", b_locked, 1);
      end
    end

    // Reset in the middle of tracking.
    applyStimulus(G, 1'b0, 1'b0);
    applyStimulus(G, 1'b1, 1'b0);
    checkOutput("midrst_locked", a_locked, 0);
    checkOutput("midrst_phase",  a_phase,  0);
    checkOutput("midrst_dwell",  a_dwell,  0);
    checkOutput("midrst_cycles", a_cyc,    0);
    checkOutput("midrst_errs",   {a_eo, a_es, a_ed, a_sticky}, 0);
    checkOutput("midrst_sticky_b", b_sticky, 0);
    applyStimulus(R, 1'b0, 1'b0);
    applyStimulus(Y, 1'b0, 1'b0);
    checkOutput("postrst_locked", a_locked, 1);
    applyStimulus(G, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
